// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer: playback modes,
// controller states and the power-up pattern RAM contents.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'd0,
    MODE_PINGPONG = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_FREEZE   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int PAT_MAX_W = 64;

  // Walking-one default: entry i lights LED (i mod width).
  function automatic logic [PAT_MAX_W-1:0] default_pattern(input int i, input int width);
    return {{(PAT_MAX_W-1){1'b0}}, 1'b1} << (i % width);
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Step-rate prescaler: counts clock cycles while running and enabled and
// fires tick every max(div,1) cycles; clear restarts the count.
module led_step_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_m1;

  // A shrinking divisor can leave cnt above the new limit; >= fires at once.
  always_comb begin
    div_m1 = (div == '0) ? '0 : div - DIV_W'(1);
    tick   = run && en && (cnt >= div_m1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (run && en) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: plays a writable DEPTH x WIDTH pattern RAM onto leds
// in loop, ping-pong, one-shot or freeze mode. Define LED_PWM_EN to add brightness PWM.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 21,
  parameter int DIV_W = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [3:0]       bright,
  output logic [WIDTH-1:0] leds,
  output logic [AW-1:0]    ptr,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             dir_down_q, dir_down_d;
  logic             done_d;
  logic             tick;
  logic             wr_hit;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] led_word;
  logic [WIDTH-1:0] ram_word [DEPTH];

  assign wr_hit = wr_en && ({{(32-AW){1'b0}}, wr_addr} < 32'(DEPTH));

  // Pattern RAM is never reset; each entry powers up with the default pattern.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ram
    logic [WIDTH-1:0] word_q = WIDTH'(default_pattern(gi, WIDTH));
    always_ff @(posedge clk) begin
      if (wr_hit && (wr_addr == AW'(gi))) begin
        word_q <= wr_data;
      end
    end
    assign ram_word[gi] = word_q;
  end

  // Same-cycle write to the displayed entry bypasses the array.
  assign rd_word = (wr_hit && (wr_addr == ptr_q)) ? wr_data : ram_word[ptr_q];

`ifdef LED_PWM_EN
  logic [3:0] pwm_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_q + 4'd1;
  end
  assign led_word = rd_word & {WIDTH{(pwm_q < bright)}};
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign led_word      = rd_word;
`endif

  led_step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start),
    .run   (state_q == RUN),
    .en    (en),
    .div   (div),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dir_down_d = dir_down_q;
    done_d     = 1'b0;
    if (start) begin
      state_d    = RUN;
      ptr_d      = '0;
      dir_down_d = 1'b0;
    end else if ((state_q == RUN) && tick) begin
      case (mode_e'(mode))
        MODE_LOOP: begin
          dir_down_d = 1'b0;
          ptr_d      = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
        end
        MODE_PINGPONG: begin
          // Endpoints are turned on, not repeated: the reversing step moves away.
          if (DEPTH == 1) begin
            ptr_d = '0;
          end else if (!dir_down_q) begin
            if (ptr_q == LAST) begin
              dir_down_d = 1'b1;
              ptr_d      = ptr_q - AW'(1);
            end else begin
              ptr_d = ptr_q + AW'(1);
            end
          end else begin
            if (ptr_q == '0) begin
              dir_down_d = 1'b0;
              ptr_d      = ptr_q + AW'(1);
            end else begin
              ptr_d = ptr_q - AW'(1);
            end
          end
        end
        MODE_ONESHOT: begin
          dir_down_d = 1'b0;
          if (ptr_q == LAST) begin
            done_d  = 1'b1;
            state_d = HOLD;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      dir_down_q <= 1'b0;
      done       <= 1'b0;
      leds       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dir_down_q <= dir_down_d;
      done       <= done_d;
      leds       <= (state_q == IDLE) ? '0 : led_word;
    end
  end

  assign ptr       = ptr_q;
  assign busy      = (state_q == RUN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: two instances (DEPTH 21 and 4) share stimulus and
// are checked every cycle against a behavioural model plus hand-computed points.
module tb_led_pattern_seq;
  import led_seq_pkg::*;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, start, wr_en;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [4:0]  wr_a21;
  logic [1:0]  wr_a4;
  logic [W-1:0] wr_data;
  logic [3:0]  bright;

  logic [W-1:0] leds21, leds4;
  logic [4:0]  ptr21;
  logic [1:0]  ptr4;
  logic        busy21, busy4, done21, done4;
  state_e      st21, st4;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  led_pattern_seq #(.WIDTH(W), .DEPTH(21), .DIV_W(16)) u21 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .mode(mode), .div(div),
    .wr_en(wr_en), .wr_addr(wr_a21), .wr_data(wr_data), .bright(bright),
    .leds(leds21), .ptr(ptr21), .busy(busy21), .done(done21), .dbg_state(st21)
  );

  led_pattern_seq #(.WIDTH(W), .DEPTH(4), .DIV_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .mode(mode), .div(div),
    .wr_en(wr_en), .wr_addr(wr_a4), .wr_data(wr_data), .bright(bright),
    .leds(leds4), .ptr(ptr4), .busy(busy4), .done(done4), .dbg_state(st4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_depth [2] = '{21, 4};
  int         m_ptr [2];
  int         m_cnt [2];
  int         m_dir [2];    // +1 up, -1 down
  int         m_phase [2];  // 0 idle, 1 running, 2 holding
  logic [W-1:0] m_leds [2];
  logic       m_done [2];
  logic [W-1:0] m_ram [2][32];
  int         m_pwm;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_cnt[k] = 0; m_dir[k] = 1; m_phase[k] = 0;
      m_leds[k] = '0; m_done[k] = 1'b0;
    end
    m_pwm = 0;
  endtask

  task automatic model_step(input int k);
    int d, dm1, wa;
    logic [W-1:0] word, mask;
    bit tick;
    d    = m_depth[k];
    dm1  = (div == 16'd0) ? 0 : int'(div) - 1;
    wa   = (k == 0) ? int'(wr_a21) : int'(wr_a4);
    word = (wr_en && wa < d && wa == m_ptr[k]) ? wr_data : m_ram[k][m_ptr[k]];
    mask = '1;
`ifdef LED_PWM_EN
    mask = (m_pwm < int'(bright)) ? '1 : '0;
`endif
    if (wr_en && wa < d) m_ram[k][wa] = wr_data;
    tick = (m_phase[k] == 1) && en && (m_cnt[k] >= dm1);
    m_leds[k] = (m_phase[k] == 0) ? '0 : (word & mask);
    m_done[k] = 1'b0;
    if (start) begin
      m_phase[k] = 1; m_ptr[k] = 0; m_cnt[k] = 0; m_dir[k] = 1;
    end else if (m_phase[k] == 1 && en) begin
      if (!tick) begin
        m_cnt[k]++;
      end else begin
        m_cnt[k] = 0;
        case (mode)
          2'd0: begin m_ptr[k] = (m_ptr[k] + 1) % d; m_dir[k] = 1; end
          2'd1: if (d > 1) begin
            if (m_ptr[k] + m_dir[k] < 0 || m_ptr[k] + m_dir[k] >= d) m_dir[k] = -m_dir[k];
            m_ptr[k] += m_dir[k];
          end
          2'd2: begin
            m_dir[k] = 1;
            if (m_ptr[k] == d - 1) begin m_done[k] = 1'b1; m_phase[k] = 2; end
            else m_ptr[k]++;
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++)
        m_ram[k][i] = (i < m_depth[k]) ? W'(1 << (i % W)) : '0;
    model_reset();
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0);
      model_step(1);
      m_pwm = (m_pwm + 1) % 16;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("leds21", leds21, m_leds[0]);
      chk("ptr21",  ptr21,  m_ptr[0]);
      chk("busy21", busy21, m_phase[0] == 1);
      chk("done21", done21, m_done[0]);
      chk("leds4",  leds4,  m_leds[1]);
      chk("ptr4",   ptr4,   m_ptr[1]);
      chk("busy4",  busy4,  m_phase[1] == 1);
      chk("done4",  done4,  m_done[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) div = 16'($urandom_range(0, 4));
      en      = ($urandom_range(0, 9) != 0);
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_a21  = 5'($urandom_range(0, 31));
      wr_a4   = 2'($urandom_range(0, 3));
      wr_data = W'($urandom);
      bright  = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  int pp_exp [21] = '{0,0,0,1,1,1,2,2,2,3,3,3,2,2,2,1,1,1,0,0,0};
  int on_cnt;

  initial begin
    en = 0; start = 0; mode = 0; div = 16'd1; wr_en = 0;
    wr_a21 = 0; wr_a4 = 0; wr_data = 0; bright = 0;
    cyc(3);
    chk("rst_leds21", leds21, 0);
    chk("rst_ptr21",  ptr21,  0);
    chk("rst_busy21", busy21, 0);
    chk("rst_done4",  done4,  0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Loop walk at one step per cycle
    en = 1; mode = 2'd0; div = 16'd1; start = 1;
    cyc(1);
    start = 0;
    cyc(5);
    chk("loop_ptr21_e5",  ptr21,  5);
    chk("loop_leds21_e5", leds21, 5'b10000);
    chk("loop_ptr4_e5",   ptr4,   1);
    cyc(16);
    chk("loop_wrap_ptr21", ptr21, 0);

    // START coincident with a tick at PTR=5
    cyc(5);
    chk("pre_start_ptr21", ptr21, 5);
    start = 1;
    cyc(1);
    start = 0;
    chk("start_wins_ptr21", ptr21, 0);

    // Write to the displayed entry while paused, then an out-of-range write
    cyc(3);
    en = 0; wr_en = 1; wr_a21 = 5'd3; wr_a4 = 2'd3; wr_data = 5'b10101;
    cyc(1);
    chk("wr_leds21", leds21, 5'b10101);
    chk("wr_leds4",  leds4,  5'b10101);
    wr_a21 = 5'd21; wr_a4 = 2'd2; wr_data = 5'b00000;
    cyc(1);
    wr_en = 0;
    chk("wr_oob_leds21", leds21, 5'b10101);
    chk("wr_oob_ptr21",  ptr21,  3);
    cyc(10);
    chk("frozen_ptr21", ptr21, 3);
    en = 1;
    cyc(1);
    chk("resume_ptr21", ptr21, 4);
    chk("resume_ptr4",  ptr4,  0);

    // One-shot with DIV=2
    mode = 2'd2; div = 16'd2; start = 1;
    cyc(1);
    start = 0;
    cyc(7);
    chk("os_ptr4_e7",  ptr4,  3);
    chk("os_done4_e7", done4, 0);
    cyc(1);
    chk("os_done4_e8", done4, 1);
    chk("os_busy4_e8", busy4, 0);
    chk("os_leds4_e8", leds4, 5'b10101);
    chk("os_ptr21_e8", ptr21, 4);
    cyc(1);
    chk("os_done4_e9", done4, 0);
    chk("os_hold_ptr4", ptr4, 3);

    // Ping-pong with DIV=3, then DIV=0
    mode = 2'd1; div = 16'd3; start = 1;
    cyc(1);
    start = 0;
    for (int i = 0; i < 21; i++) begin
      chk("pp_ptr4", ptr4, pp_exp[i]);
      cyc(1);
    end
    div = 16'd0;
    cyc(1);
    chk("div0_ptr4_a", ptr4, 2);
    cyc(1);
    chk("div0_ptr4_b", ptr4, 3);
    cyc(1);
    chk("div0_ptr4_c", ptr4, 2);

    rand_phase(2500);

    // Asynchronous reset mid-run
    en = 1; mode = 2'd0; div = 16'd1; start = 1;
    cyc(1);
    start = 0;
    cyc(4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_leds21", leds21, 0);
    chk("async_ptr21",  ptr21,  0);
    chk("async_busy4",  busy4,  0);
    chk("async_leds4",  leds4,  0);
    cyc(2);
    rst_n = 1'b1;

    rand_phase(1500);

    // Brightness: all-ones word held by freeze mode
    wr_en = 1; wr_a21 = 0; wr_a4 = 0; wr_data = 5'b11111;
    mode = 2'd3; div = 16'd1; en = 1; start = 1; bright = 4'd4;
    cyc(1);
    wr_en = 0; start = 0;
    cyc(2);
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (leds21 == 5'b11111) on_cnt++;
      cyc(1);
    end
`ifdef LED_PWM_EN
    chk("pwm_b4_on_cycles", on_cnt, 4);
`else
    chk("nopwm_on_cycles", on_cnt, 16);
`endif
    bright = 4'd0;
    cyc(2);
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (leds21 != 5'b00000) on_cnt++;
      cyc(1);
    end
`ifdef LED_PWM_EN
    chk("pwm_b0_on_cycles", on_cnt, 0);
`else
    chk("nopwm_b0_on_cycles", on_cnt, 16);
`endif

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Parametrised LED pattern sequencer. A writable pattern RAM of DEPTH words, each WIDTH bits, is played out on LEDS.
- The step rate comes from a runtime prescaler. Four playback modes: loop, ping-pong, one-shot, freeze.
- Sits in the SOC top between the clock/reset pins and the LEDS pins. It is the generalised successor of the fixed 5-bit, 21-step free-running LED ROM sequencer.

Parameters:
- WIDTH, 5: LED/pattern word width.
- DEPTH, 21: pattern entries, legal range 1..256.
- DIV_W, 16: width of the prescaler divisor input.
- AW, $clog2(DEPTH) (min 1): address width. Derived; not overridden.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- EN  in  1  run enable; 0 pauses playback (state held).
- START  in  1  one-cycle pulse: restart playback from entry 0.
- MODE  in  2  0=loop, 1=ping-pong, 2=one-shot, 3=freeze.
- DIV  in  DIV_W  clock cycles per step; 0 treated as 1.
- WR_EN  in  1  pattern RAM write strobe.
- WR_ADDR  in  AW  write address; writes with address >= DEPTH are ignored.
- WR_DATA  in  WIDTH  write data.
- BRIGHT  in  4  brightness; used only with LED_PWM_EN.
- LEDS  out  WIDTH  registered LED drive.
- PTR  out  AW  current pattern index.
- BUSY  out  1  high in RUN state.
- DONE  out  1  one-cycle pulse at one-shot completion.

Behaviour:
- Reset (RESET=0, async):
  - State=IDLE; PTR=0; LEDS=0; BUSY=0; DONE=0; dir=up; prescaler cnt=0.
  - RAM contents are not reset. At power-up they hold PKG default: entry i = 1<<(i mod WIDTH).
- States and transitions:
  - IDLE -> RUN on START.
  - RUN -> HOLD when a one-shot reaches DEPTH-1 and its step tick fires.
  - HOLD -> RUN on START.
  - START in any state: PTR=0, cnt=0, dir=up, state=RUN next cycle.
- Tick generation:
  - In RUN with EN=1, cnt increments each cycle.
  - tick = (cnt == max(DIV,1)-1); on tick, cnt=0.
  - EN=0 freezes cnt and PTR.
  - A DIV change takes effect from the next compare. If cnt is already >= new DIV-1, tick fires on the next cycle.
- Step on tick, by mode:
  - Loop: PTR = (PTR==DEPTH-1) ? 0 : PTR+1.
  - Ping-pong: reverse direction at either end. Endpoints are shown once per turn, e.g. DEPTH=4 gives 0,1,2,3,2,1,0,1.
  - One-shot: at DEPTH-1, pulse DONE for one cycle, go to HOLD, keep PTR=DEPTH-1.
  - Freeze: PTR unchanged; cnt keeps running.
- Mode changes:
  - A MODE change applies at the next tick; PTR is never reset by it.
  - Leaving ping-pong with dir=down: loop/one-shot resume counting up from the current PTR.
- DEPTH=1: PTR stays 0. One-shot completes on the first tick.
- LEDS:
  - LEDS <= RAM[PTR] every cycle in RUN and HOLD; 0 in IDLE. Latency is one cycle from PTR.
  - Write-before-read: a RAM write to the current PTR appears on LEDS the cycle after the write.
- Simultaneous events:
  - START and tick in the same cycle: START wins.
  - WR_EN and START in the same cycle: both take effect.

Optional Feature:
- LED_PWM_EN defined:
  - A 4-bit free-running PWM counter p (reset 0) increments every cycle.
  - LEDS = RAM-word AND {WIDTH{p < BRIGHT}}. BRIGHT=0 gives all off; BRIGHT=15 gives 15/16 duty.
- Not defined: BRIGHT is ignored and LEDS is the raw word as above.

Decomposition:
- Package led_seq_pkg holds:
  - mode enum (MODE_LOOP, MODE_PINGPONG, MODE_ONESHOT, MODE_FREEZE);
  - state enum (IDLE, RUN, HOLD);
  - default_pattern(i, width) function.
- One sub-module, led_step_prescaler: cnt, DIV=0 handling, tick output.

Test Plan:
- Reset, START, DIV=1, MODE=0, DEPTH=21 -> LEDS walks default entries, PTR wraps 20->0 after 21 cycles. Mid-run RESET low -> LEDS=0, PTR=0 immediately, no clock needed.
- DIV=3, MODE=1, DEPTH=4 -> PTR sequence 0,1,2,3,2,1,0 with each value held 3 cycles. DIV=0 -> steps every cycle.
- MODE=2, DEPTH=4, DIV=2 -> DONE high exactly one cycle after PTR=3 tick, BUSY=0, LEDS=RAM[3] held. START -> restart at 0.
- Write WR_ADDR=PTR, WR_DATA=5'b10101 during RUN, EN=0 -> LEDS=10101 next cycle. WR_ADDR=DEPTH -> no change anywhere.
- START coincident with tick at PTR=5 -> PTR=0, not 6. EN toggled 0 for 10 cycles -> PTR and cnt frozen, resume exactly.
- LED_PWM_EN, RAM word all-ones, BRIGHT=4 -> each LED high 4 of every 16 cycles. BRIGHT=0 -> LEDS=0 constantly.
